// File: rtl/dcache_load_port_pkg.sv
// Shared types and sizing for the dcache load port and its MSHR table.
// Line geometry: 32 direct-mapped sets of 8-byte lines.
package dcache_load_port_pkg;

   localparam int NUM_LU_DCACHE = 2;
   localparam int NUM_SETS      = 32;
   localparam int NUM_MSHR      = 4;
   localparam int MEM_TAG_W     = 4;

   localparam int SET_W      = $clog2(NUM_SETS);
   localparam int BLOCK_W    = 29;
   localparam int TAG_W      = BLOCK_W - SET_W;
   localparam int MSHR_IDX_W = $clog2(NUM_MSHR);

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } LQ_DCACHE_PACKET;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [63:0] data;
   } DCACHE_LQ_PACKET;

   typedef struct packed {
      logic                 valid;
      logic [BLOCK_W-1:0]   block;
      logic [MEM_TAG_W-1:0] mem_tag;
   } DCACHE_MSHR_ENTRY;

   localparam int LQ_PKT_W   = $bits(LQ_DCACHE_PACKET);
   localparam int FILL_PKT_W = $bits(DCACHE_LQ_PACKET);

   function automatic logic [31:0] word_sel(
      input logic [63:0] line,
      input logic        word
   );
      return word ? line[63:32] : line[31:0];
   endfunction

endpackage

// File: rtl/dcache_mshr_table.sv
// Miss status holding registers: block CAM for lookups, tag CAM for
// returning fills, lowest-free-slot allocation.
module dcache_mshr_table
   import dcache_load_port_pkg::*;
#(
   parameter int NUM_PORTS = NUM_LU_DCACHE
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_PORTS*BLOCK_W-1:0] lookup_block_i,
   output logic [NUM_PORTS-1:0]         match_o,
   output logic                         free_avail_o,
   input  logic                         alloc_i,
   input  logic [BLOCK_W-1:0]           alloc_block_i,
   input  logic [MEM_TAG_W-1:0]         alloc_tag_i,
   input  logic [MEM_TAG_W-1:0]         resp_tag_i,
   output logic                         fill_o,
   output logic [BLOCK_W-1:0]           fill_block_o
);

   DCACHE_MSHR_ENTRY [NUM_MSHR-1:0] mshr_q, mshr_d;
   logic [MSHR_IDX_W-1:0]           free_idx;
   logic [MSHR_IDX_W-1:0]           fill_idx;

   always_comb begin
      match_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int m = 0; m < NUM_MSHR; m++) begin
            if (mshr_q[m].valid &&
                mshr_q[m].block == lookup_block_i[p*BLOCK_W +: BLOCK_W])
               match_o[p] = 1'b1;
         end
      end
   end

   // Descending scans so the lowest matching index is the one kept.
   always_comb begin
      free_avail_o = 1'b0;
      free_idx     = '0;
      fill_o       = 1'b0;
      fill_idx     = '0;
      for (int m = NUM_MSHR - 1; m >= 0; m--) begin
         if (!mshr_q[m].valid) begin
            free_avail_o = 1'b1;
            free_idx     = MSHR_IDX_W'(m);
         end
         if (resp_tag_i != '0 && mshr_q[m].valid &&
             mshr_q[m].mem_tag == resp_tag_i) begin
            fill_o   = 1'b1;
            fill_idx = MSHR_IDX_W'(m);
         end
      end
   end

   assign fill_block_o = mshr_q[fill_idx].block;

   always_comb begin
      mshr_d = mshr_q;
      if (fill_o)
         mshr_d[fill_idx].valid = 1'b0;
      if (alloc_i && free_avail_o) begin
         mshr_d[free_idx].valid   = 1'b1;
         mshr_d[free_idx].block   = alloc_block_i;
         mshr_d[free_idx].mem_tag = alloc_tag_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         mshr_q <= '0;
      else
         mshr_q <= mshr_d;
   end

endmodule

// File: rtl/dcache_load_port.sv
// Dcache responder for load-queue requests: hit data, MSHR misses, fill broadcast.
// Build option DCACHE_MISS_MERGE_EN accepts loads to blocks already in flight.
module dcache_load_port
   import dcache_load_port_pkg::*;
#(
   parameter int NUM_PORTS = NUM_LU_DCACHE
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_PORTS*LQ_PKT_W-1:0]       lq_dcache_packet,
   output logic [NUM_PORTS-1:0]                load_req_accept,
   output logic [NUM_PORTS*32-1:0]             load_req_data,
   output logic [NUM_PORTS-1:0]                load_req_data_valid,
   output logic [NUM_LU_DCACHE*FILL_PKT_W-1:0] dcache_lq_packet,
   output logic                                mem_req_valid,
   output logic [31:0]                         mem_req_addr,
   input  logic [MEM_TAG_W-1:0]                mem_req_tag,
   input  logic [MEM_TAG_W-1:0]                mem_resp_tag,
   input  logic [63:0]                         mem_resp_data
);

`ifdef DCACHE_MISS_MERGE_EN
   localparam logic MERGE_EN = 1'b1;
`else
   localparam logic MERGE_EN = 1'b0;
`endif

   logic [NUM_SETS-1:0] lvalid_q;
   logic [TAG_W-1:0]    ltag_q  [NUM_SETS];
   logic [63:0]         ldata_q [NUM_SETS];

   LQ_DCACHE_PACKET      req     [NUM_PORTS];
   logic [BLOCK_W-1:0]   blk     [NUM_PORTS];
   logic [SET_W-1:0]     set_idx [NUM_PORTS];
   logic [TAG_W-1:0]     tag     [NUM_PORTS];
   logic [31:0]          rd_word [NUM_PORTS];
   logic [NUM_PORTS-1:0] hit;
   logic [NUM_PORTS-1:0] unused_offset;

   logic [NUM_PORTS*BLOCK_W-1:0] lookup_flat;
   logic [NUM_PORTS-1:0]         mshr_match;
   logic                         free_avail;
   logic                         fill;
   logic [BLOCK_W-1:0]           fill_blk;

   logic                 prim_found;
   logic                 alloc;
   logic [BLOCK_W-1:0]   win_blk;
   logic [NUM_PORTS-1:0] accept;

   logic [NUM_PORTS-1:0]    dv_q, dv_d;
   logic [NUM_PORTS*32-1:0] data_q, data_d;
   DCACHE_LQ_PACKET         fill_q, fill_d;

   always_comb begin
      lookup_flat   = '0;
      hit           = '0;
      unused_offset = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         req[p]     = lq_dcache_packet[p*LQ_PKT_W +: LQ_PKT_W];
         blk[p]     = req[p].addr[31:3];
         set_idx[p] = req[p].addr[3 +: SET_W];
         tag[p]     = req[p].addr[31 -: TAG_W];
         rd_word[p] = word_sel(ldata_q[set_idx[p]], req[p].addr[2]);
         hit[p]     = req[p].valid && lvalid_q[set_idx[p]] &&
                      ltag_q[set_idx[p]] == tag[p];
         unused_offset[p] = ^req[p].addr[1:0];
         lookup_flat[p*BLOCK_W +: BLOCK_W] = blk[p];
      end
   end

   dcache_mshr_table #(
      .NUM_PORTS(NUM_PORTS)
   ) u_mshr (
      .clk_i         (clock),
      .rst_ni        (reset),
      .lookup_block_i(lookup_flat),
      .match_o       (mshr_match),
      .free_avail_o  (free_avail),
      .alloc_i       (alloc),
      .alloc_block_i (win_blk),
      .alloc_tag_i   (mem_req_tag),
      .resp_tag_i    (mem_resp_tag),
      .fill_o        (fill),
      .fill_block_o  (fill_blk)
   );

   // Ports are walked in index order so the lowest primary miss owns
   // the single memory request and later ports see its allocation.
   always_comb begin
      accept     = '0;
      prim_found = 1'b0;
      alloc      = 1'b0;
      win_blk    = '0;
      if (reset) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!req[p].valid) begin
               accept[p] = 1'b0;
            end else if (hit[p]) begin
               accept[p] = 1'b1;
            end else if (mshr_match[p] || (alloc && win_blk == blk[p])) begin
               accept[p] = MERGE_EN;
            end else if (!prim_found) begin
               prim_found = 1'b1;
               win_blk    = blk[p];
               if (mem_req_tag != '0 && free_avail) begin
                  alloc     = 1'b1;
                  accept[p] = 1'b1;
               end
            end
         end
      end
   end

   assign load_req_accept = accept;
   assign mem_req_valid   = prim_found && free_avail;
   assign mem_req_addr    = mem_req_valid ? {win_blk, 3'b000} : '0;

   always_comb begin
      dv_d   = '0;
      data_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (hit[p]) begin
            dv_d[p]             = 1'b1;
            data_d[p*32 +: 32]  = rd_word[p];
         end
      end
      fill_d = '0;
      if (fill) begin
         fill_d.valid = 1'b1;
         fill_d.addr  = {fill_blk, 3'b000};
         fill_d.data  = mem_resp_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lvalid_q <= '0;
         dv_q     <= '0;
         data_q   <= '0;
         fill_q   <= '0;
      end else begin
         if (fill)
            lvalid_q[fill_blk[SET_W-1:0]] <= 1'b1;
         dv_q   <= dv_d;
         data_q <= data_d;
         fill_q <= fill_d;
      end
   end

   // Tag/data storage needs no reset; lvalid_q guards every read.
   always_ff @(posedge clock) begin
      if (fill) begin
         ltag_q[fill_blk[SET_W-1:0]]  <= fill_blk[BLOCK_W-1:SET_W];
         ldata_q[fill_blk[SET_W-1:0]] <= mem_resp_data;
      end
   end

   always_comb begin
      dcache_lq_packet = '0;
      dcache_lq_packet[FILL_PKT_W-1:0] = fill_q;
   end

   assign load_req_data       = data_q;
   assign load_req_data_valid = dv_q;

endmodule
